pat_scan_ctrl: RTL and testbench

Frame-level controller that feeds a serial pattern detector from a word-wide stream. It accepts words through a valid/ready handshake and serialises them MSB-first, one bit per clock, into an embedded configurable matcher. It counts pattern hits per frame and reports the total at frame end. It sits between a byte/word source and the downstream status/interrupt logic, replacing hard-wired single-pattern detectors.

---
 rtl/pat_scan_pkg.sv | 15 +
 rtl/pat_scan_ctrl_if.sv | 25 ++
 rtl/pat_match_core.sv | 50 +++++
 rtl/pat_scan_ctrl.sv | 179 +++++++++++++++++
 tb/tb_pat_scan_ctrl.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/pat_scan_pkg.sv
// Shared types and default widths for the pattern-scan controller.
package pat_scan_pkg;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_PAT_LEN = 5;
  localparam int DEF_CNT_W   = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCEPT = 2'd1,
    SHIFT  = 2'd2,
    REPORT = 2'd3
  } state_t;

endpackage

// File: rtl/pat_scan_ctrl_if.sv
// Word stream valid/ready handshake feeding the pattern-scan controller.
interface pat_scan_ctrl_if #(
  parameter int DATA_W = 8
) ();

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;

  modport master (
    output in_valid,
    output in_data,
    output in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    output in_ready
  );

endinterface

// File: rtl/pat_match_core.sv
// Serial matcher: history shift register, saturating fill count, registered hit.
module pat_match_core #(
  parameter int PAT_LEN = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               bit_in,
  input  logic               bit_valid,
  input  logic               clear,
  input  logic [PAT_LEN-1:0] pattern,
  input  logic               overlap,
  output logic               hit,
  output logic               hit_nxt
);

  localparam int FILL_W = $clog2(PAT_LEN + 1);

  logic [PAT_LEN-1:0] r_hist;
  logic [FILL_W-1:0]  r_fill;
  logic               r_hit;
  logic [PAT_LEN-1:0] w_hist_nxt;
  logic [FILL_W-1:0]  w_fill_nxt;
  logic               w_hit;

  // Evaluate the match against the history as it will look once this bit lands.
  always_comb begin
    w_hist_nxt = {r_hist[PAT_LEN-2:0], bit_in};
    w_fill_nxt = (r_fill == FILL_W'(PAT_LEN)) ? r_fill : r_fill + FILL_W'(1);
    w_hit      = bit_valid && (w_fill_nxt == FILL_W'(PAT_LEN)) && (w_hist_nxt == pattern);
  end

  // History and fill update; non-overlap mode restarts the fill but keeps the bits.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_hist <= '0;
      r_fill <= '0;
      r_hit  <= 1'b0;
    end else if (bit_valid) begin
      r_hist <= w_hist_nxt;
      r_fill <= (w_hit && !overlap) ? FILL_W'(0) : w_fill_nxt;
      r_hit  <= w_hit;
    end else begin
      r_hit  <= 1'b0;
    end
  end

  assign hit     = r_hit;
  assign hit_nxt = w_hit;

endmodule

// File: rtl/pat_scan_ctrl.sv
// Frame controller: serialises handshaked words MSB-first into pat_match_core and counts hits.
// Define PAT_SCAN_IRQ_EN to add the sticky irq output with irq_clr.
module pat_scan_ctrl
  import pat_scan_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int PAT_LEN = DEF_PAT_LEN,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [PAT_LEN-1:0] cfg_pattern,
  input  logic               cfg_overlap,
  pat_scan_ctrl_if.slave     s_in,
  output logic               busy,
  output logic               det_pulse,
  output logic               frame_done,
  output logic [CNT_W-1:0]   match_count,
  output logic               overflow
`ifdef PAT_SCAN_IRQ_EN
  ,
  input  logic               irq_clr,
  output logic               irq
`endif
);

  localparam int BCW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [DATA_W-1:0]  r_shift;
  logic               r_last;
  logic [BCW-1:0]     r_bitcnt;
  logic [PAT_LEN-1:0] r_pattern;
  logic               r_overlap;
  logic [CNT_W-1:0]   r_count;
  logic               r_overflow;
  logic               w_in_ready;
  logic               w_busy;
  logic               w_frame_done;
  logic               w_start_acc;
  logic               w_load;
  logic               w_shift;
  logic               w_hit;
  logic               w_hit_nxt;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and state-decoded controls; in_ready depends on state alone.
  always_comb begin
    w_state_nxt  = r_state;
    w_in_ready   = 1'b0;
    w_busy       = 1'b1;
    w_frame_done = 1'b0;
    w_start_acc  = 1'b0;
    w_load       = 1'b0;
    w_shift      = 1'b0;
    case (r_state)
      IDLE: begin
        w_busy = 1'b0;
        if (start) begin
          w_start_acc = 1'b1;
          w_state_nxt = ACCEPT;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      ACCEPT: begin
        w_in_ready = 1'b1;
        if (s_in.in_valid) begin
          w_load      = 1'b1;
          w_state_nxt = SHIFT;
        end else begin
          w_state_nxt = ACCEPT;
        end
      end
      SHIFT: begin
        w_shift = 1'b1;
        if (r_bitcnt == BCW'(0)) begin
          w_state_nxt = r_last ? REPORT : ACCEPT;
        end else begin
          w_state_nxt = SHIFT;
        end
      end
      REPORT: begin
        w_frame_done = 1'b1;
        w_state_nxt  = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Config latch, word shifter and saturating hit counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift    <= '0;
      r_last     <= 1'b0;
      r_bitcnt   <= '0;
      r_pattern  <= '0;
      r_overlap  <= 1'b0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_start_acc) begin
        r_pattern  <= cfg_pattern;
        r_overlap  <= cfg_overlap;
        r_count    <= '0;
        r_overflow <= 1'b0;
      end
      if (w_load) begin
        r_shift  <= s_in.in_data;
        r_last   <= s_in.in_last;
        r_bitcnt <= BCW'(DATA_W - 1);
      end else if (w_shift) begin
        r_shift  <= r_shift << 1;
        r_bitcnt <= r_bitcnt - BCW'(1);
      end
      // Count lands with the registered pulse, so a final-bit hit is visible in REPORT.
      if (w_hit_nxt) begin
        if (r_count == {CNT_W{1'b1}}) begin
          r_overflow <= 1'b1;
        end else begin
          r_count <= r_count + CNT_W'(1);
        end
      end
    end
  end

  pat_match_core #(
    .PAT_LEN (PAT_LEN)
  ) u_core (
    .clk       (clk),
    .reset     (reset),
    .bit_in    (r_shift[DATA_W-1]),
    .bit_valid (w_shift),
    .clear     (w_start_acc),
    .pattern   (r_pattern),
    .overlap   (r_overlap),
    .hit       (w_hit),
    .hit_nxt   (w_hit_nxt)
  );

`ifdef PAT_SCAN_IRQ_EN
  logic r_irq;

  // Sticky interrupt; a coinciding set beats the clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_irq <= 1'b0;
    end else if (w_frame_done && ((r_count != CNT_W'(0)) || r_overflow)) begin
      r_irq <= 1'b1;
    end else if (irq_clr) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= r_irq;
    end
  end

  assign irq = r_irq;
`endif

  assign s_in.in_ready = w_in_ready;
  assign busy          = w_busy;
  assign frame_done    = w_frame_done;
  assign det_pulse     = w_hit;
  assign match_count   = r_count;
  assign overflow      = r_overflow;

endmodule

// File: tb/tb_pat_scan_ctrl.sv
// Directed self-checking bench for pat_scan_ctrl (default and CNT_W=2 instances).
module tb_pat_scan_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       start2;
  logic [4:0] cfg_pattern;
  logic       cfg_overlap;
  logic       busy, det_pulse, frame_done, overflow;
  logic [7:0] match_count;
  logic       busy2, det2, fd2, ovf2;
  logic [1:0] cnt2;
`ifdef PAT_SCAN_IRQ_EN
  logic       irq_clr = 1'b0;
  logic       irq, irq2;
`endif

  int checks = 0;
  int errors = 0;
  int n_pulse = 0;
  int n_pulse2 = 0;

  pat_scan_ctrl_if #(.DATA_W(8)) u_if ();
  pat_scan_ctrl_if #(.DATA_W(8)) u_if2 ();

  pat_scan_ctrl #(.DATA_W(8), .PAT_LEN(5), .CNT_W(8)) u_dut (
    .clk(clk), .reset(reset), .start(start), .cfg_pattern(cfg_pattern), .cfg_overlap(cfg_overlap),
    .s_in(u_if), .busy(busy), .det_pulse(det_pulse), .frame_done(frame_done),
    .match_count(match_count), .overflow(overflow)
`ifdef PAT_SCAN_IRQ_EN
    , .irq_clr(irq_clr), .irq(irq)
`endif
  );

  pat_scan_ctrl #(.DATA_W(8), .PAT_LEN(5), .CNT_W(2)) u_dut2 (
    .clk(clk), .reset(reset), .start(start2), .cfg_pattern(cfg_pattern), .cfg_overlap(cfg_overlap),
    .s_in(u_if2), .busy(busy2), .det_pulse(det2), .frame_done(fd2),
    .match_count(cnt2), .overflow(ovf2)
`ifdef PAT_SCAN_IRQ_EN
    , .irq_clr(irq_clr), .irq(irq2)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (det_pulse) n_pulse <= n_pulse + 1;
    if (det2) n_pulse2 <= n_pulse2 + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic do_start(input string tag, input logic [4:0] pat, input logic ovl);
    cfg_pattern = pat;
    cfg_overlap = ovl;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cfg_pattern = ~pat;
    cfg_overlap = ~ovl;
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
  endtask

  // Returns on the first negedge after the handshake edge.
  task automatic send_word(input string tag, input logic [7:0] d, input logic l);
    int n = 0;
    u_if.in_valid = 1'b1;
    u_if.in_data  = d;
    u_if.in_last  = l;
    while (!u_if.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ready_to"}, {31'd0, u_if.in_ready}, 32'd1);
    @(negedge clk);
    u_if.in_valid = 1'b0;
  endtask

  task automatic wait_report(input string tag, input int p0, input int exp_cnt, input int exp_pulses);
    int k = 1;
    while (!frame_done && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_dur"}, k, 32'd9);
    chk({tag, "_count"}, {24'd0, match_count}, exp_cnt);
    chk({tag, "_ovf"}, {31'd0, overflow}, 32'd0);
    @(negedge clk);
    chk({tag, "_pulses"}, n_pulse - p0, exp_pulses);
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int p0;
    int n;
    int k;
    logic fd_seen;
    reset = 1'b1;
    start = 1'b0;
    start2 = 1'b0;
    cfg_pattern = 5'd0;
    cfg_overlap = 1'b0;
    u_if.in_valid = 1'b0;  u_if.in_data = 8'd0;  u_if.in_last = 1'b0;
    u_if2.in_valid = 1'b0; u_if2.in_data = 8'd0; u_if2.in_last = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ready", {31'd0, u_if.in_ready}, 32'd0);
    chk("rst_det", {31'd0, det_pulse}, 32'd0);
    chk("rst_fd", {31'd0, frame_done}, 32'd0);
    chk("rst_count", {24'd0, match_count}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // AA against 10101, no overlap: one hit after bit 5
    do_start("t1", 5'b10101, 1'b0);
    chk("t1_ready", {31'd0, u_if.in_ready}, 32'd1);
    p0 = n_pulse;
    send_word("t1", 8'hAA, 1'b1);
    wait_report("t1", p0, 1, 1);
    repeat (3) @(negedge clk);
    chk("t1_hold", {24'd0, match_count}, 32'd1);

    // Same word with overlap: hits after bits 5 and 7
    do_start("t2", 5'b10101, 1'b1);
    p0 = n_pulse;
    send_word("t2", 8'hAA, 1'b1);
    wait_report("t2", p0, 2, 2);

    // 01 then 50: the single hit straddles the word boundary
    do_start("t3", 5'b10101, 1'b0);
    p0 = n_pulse;
    send_word("t3a", 8'h01, 1'b0);
    send_word("t3b", 8'h50, 1'b1);
    wait_report("t3", p0, 1, 1);

    // CNT_W=2 all-zero pattern: four hits, counter saturates at 3
    cfg_pattern = 5'b00000;
    cfg_overlap = 1'b1;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    p0 = n_pulse2;
    u_if2.in_valid = 1'b1; u_if2.in_data = 8'h00; u_if2.in_last = 1'b1;
    n = 0;
    while (!u_if2.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t4_ready_to", {31'd0, u_if2.in_ready}, 32'd1);
    @(negedge clk);
    u_if2.in_valid = 1'b0;
    k = 1;
    while (!fd2 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("t4_dur", k, 32'd9);
    chk("t4_count", {30'd0, cnt2}, 32'd3);
    chk("t4_ovf", {31'd0, ovf2}, 32'd1);
    @(negedge clk);
    chk("t4_pulses", n_pulse2 - p0, 32'd4);

    // Source stall with an ignored start and new config mid-frame
    do_start("t5", 5'b10101, 1'b1);
    p0 = n_pulse;
    send_word("t5a", 8'h15, 1'b0);
    n = 0;
    while (!u_if.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      chk("t5_stall_ready", {31'd0, u_if.in_ready}, 32'd1);
      if (i == 1) begin
        start = 1'b1;
        cfg_pattern = 5'b01010;
        cfg_overlap = 1'b0;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    send_word("t5b", 8'h40, 1'b1);
    wait_report("t5", p0, 2, 2);

    // Reset during the second word's shift, then a clean frame
    do_start("t6", 5'b10101, 1'b0);
    send_word("t6a", 8'hAA, 1'b0);
    send_word("t6b", 8'h55, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("t6_busy", {31'd0, busy}, 32'd0);
    chk("t6_ready", {31'd0, u_if.in_ready}, 32'd0);
    chk("t6_det", {31'd0, det_pulse}, 32'd0);
    chk("t6_fd", {31'd0, frame_done}, 32'd0);
    chk("t6_count", {24'd0, match_count}, 32'd0);
    chk("t6_ovf", {31'd0, overflow}, 32'd0);
    reset = 1'b0;
    fd_seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (frame_done) fd_seen = 1'b1;
    end
    chk("t6_no_fd", {31'd0, fd_seen}, 32'd0);
    do_start("t7", 5'b10101, 1'b0);
    p0 = n_pulse;
    send_word("t7", 8'hAA, 1'b1);
    wait_report("t7", p0, 1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
